// File: rtl/bist_lfsr_tpg.sv
// BIST stimulus generator: Fibonacci LFSR sequenced by a pattern counter.
// Raises bist_end after N_PATTERNS vectors so that the downstream compactor freezes.
//
// state | meaning
// IDLE  | no run; all outputs at zero
// RUN   | one LFSR vector per cycle is presented to the CUT
// DONE  | run complete; last vector held, bist_end high
module bist_lfsr_tpg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter int               N_PATTERNS = 200,
  parameter int               CW         = $clog2(N_PATTERNS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic [CW-1:0]    pattern_cnt,
  output logic             bist_end,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N_PATTERNS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_seed;
  logic             w_fb;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed = (seed == '0) ? WIDTH'(1) : seed;
  assign w_fb   = ^(r_lfsr & TAPS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_lfsr  <= WIDTH'(1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_lfsr_nxt  = w_seed;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_lfsr_nxt = {r_lfsr[WIDTH-2:0], w_fb};
          w_cnt_nxt  = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // Outputs decode straight from flops; the LFSR holds the last vector in DONE.
  always_comb begin
    pattern       = '0;
    pattern_valid = 1'b0;
    pattern_cnt   = '0;
    bist_end      = 1'b0;
    busy          = 1'b0;
    case (r_state)
      S_RUN: begin
        pattern       = r_lfsr;
        pattern_valid = 1'b1;
        pattern_cnt   = r_cnt;
        busy          = 1'b1;
      end
      S_DONE: begin
        pattern     = r_lfsr;
        pattern_cnt = r_cnt;
        bist_end    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bist_lfsr_tpg.sv
// Self-checking bench for bist_lfsr_tpg: a 200-vector and a 255-vector instance
// share stimulus and are compared every cycle with a behavioural run model.
module tb_bist_lfsr_tpg;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       abort;
  logic [7:0] seed;

  logic [7:0] p0, p1;
  logic       v0, v1, e0, e1, b0, b1;
  logic [7:0] c0, c1;

  bist_lfsr_tpg #(.WIDTH(8), .TAPS(8'hB8), .N_PATTERNS(200)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .seed(seed),
    .pattern(p0), .pattern_valid(v0), .pattern_cnt(c0), .bist_end(e0), .busy(b0)
  );

  bist_lfsr_tpg #(.WIDTH(8), .TAPS(8'hB8), .N_PATTERNS(255)) dut255 (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .seed(seed),
    .pattern(p1), .pattern_valid(v1), .pattern_cnt(c1), .bist_end(e1), .busy(b1)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: phase 0 = idle, 1 = running, 2 = finished
  int         m_phase [2];
  int         m_idx   [2];
  logic [7:0] m_seed0 [2];
  int         m_n     [2];

  function automatic logic [7:0] lfsr_next(logic [7:0] v);
    logic [7:0] taps;
    int ones;
    taps = 8'hB8;
    ones = 0;
    for (int i = 0; i < 8; i++) if (v[i] && taps[i]) ones++;
    return 8'((int'(v) * 2) + (ones % 2));
  endfunction

  function automatic logic [7:0] nth_vector(logic [7:0] s, int k);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < k; i++) v = lfsr_next(v);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int j = 0; j < 2; j++) begin
      if (RST || abort) begin
        m_phase[j] = 0;
        m_idx[j]   = 0;
      end else if (m_phase[j] == 1) begin
        if (m_idx[j] == m_n[j] - 1) m_phase[j] = 2;
        else m_idx[j]++;
      end else if (start) begin
        m_phase[j] = 1;
        m_idx[j]   = 0;
        m_seed0[j] = (seed == 8'h00) ? 8'h01 : seed;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] ep, op, oc;
    logic       ev, ee, eb, ov, oe, ob;
    int         ec;
    for (int j = 0; j < 2; j++) begin
      ep = 8'h00; ev = 1'b0; ec = 0; ee = 1'b0; eb = 1'b0;
      if (m_phase[j] == 1) begin
        ep = nth_vector(m_seed0[j], m_idx[j]); ev = 1'b1; ec = m_idx[j]; eb = 1'b1;
      end else if (m_phase[j] == 2) begin
        ep = nth_vector(m_seed0[j], m_n[j] - 1); ec = m_n[j] - 1; ee = 1'b1;
      end
      if (j == 0) begin op = p0; ov = v0; oc = c0; oe = e0; ob = b0; end
      else        begin op = p1; ov = v1; oc = c1; oe = e1; ob = b1; end
      chk($sformatf("pattern[%0d]", j), 32'(op), 32'(ep));
      chk($sformatf("valid[%0d]", j),   32'(ov), 32'(ev));
      chk($sformatf("cnt[%0d]", j),     32'(oc), 32'(ec));
      chk($sformatf("end[%0d]", j),     32'(oe), 32'(ee));
      chk($sformatf("busy[%0d]", j),    32'(ob), 32'(eb));
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  logic [7:0] exp_seq [6];
  logic [7:0] run1 [200];
  bit         seen [256];
  int         n_valid0, max_cnt0, n_valid1, n_rep, n_distinct;

  initial begin
    m_n[0] = 200;
    m_n[1] = 255;
    for (int j = 0; j < 2; j++) begin m_phase[j] = 0; m_idx[j] = 0; m_seed0[j] = 8'h01; end
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    // Reset with random start/abort asserted alongside
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      seed  = 8'($urandom);
      cycle();
    end
    RST = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) cycle();

    // Sequence, run length, period; a start during RUN is ignored
    seed = 8'h01; start = 1'b1;
    cycle();
    start = 1'b0;
    n_valid0 = 0; max_cnt0 = 0; n_valid1 = 0; n_rep = 0;
    for (int i = 0; i < 270; i++) begin
      if (i < 6) chk("seq_vector", 32'(p0), 32'(exp_seq[i]));
      if (v0) n_valid0++;
      if (int'(c0) > max_cnt0) max_cnt0 = int'(c0);
      if (v1) begin
        if (seen[p1]) n_rep++;
        seen[p1] = 1'b1;
        n_valid1++;
      end
      if (i == 20) begin start = 1'b1; seed = 8'h5A; end
      else start = 1'b0;
      cycle();
    end
    n_distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) n_distinct++;
    chk("valid_cycles_200", 32'(n_valid0), 32'd200);
    chk("max_cnt_199", 32'(max_cnt0), 32'd199);
    chk("valid_cycles_255", 32'(n_valid1), 32'd255);
    chk("period_repeats", 32'(n_rep), 32'd0);
    chk("period_distinct", 32'(n_distinct), 32'd255);
    repeat (50) cycle();
    chk("end_held", 32'(e0), 32'd1);

    // Zero seed, then abort at vector 50
    seed = 8'h00; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("zero_seed_v0", 32'(p0), 32'h01);
    cycle();
    chk("zero_seed_v1", 32'(p0), 32'h02);
    for (int i = 0; i < 100 && c0 != 8'd50; i++) cycle();
    chk("reach_vec50", 32'(c0), 32'd50);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_valid", 32'(v0), 32'd0);
    chk("abort_cnt", 32'(c0), 32'd0);
    chk("abort_end", 32'(e0), 32'd0);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1; seed = 8'h33;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 32'(b0), 32'd0);
    cycle();

    // Restart from DONE with seed A5; second run must match the first
    seed = 8'hA5; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin run1[i] = p0; cycle(); end
    repeat (60) cycle();
    chk("done_before_restart", 32'(e0), 32'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_end_drop", 32'(e0), 32'd0);
    chk("restart_first", 32'(p0), 32'hA5);
    for (int i = 0; i < 200; i++) begin
      if (i == 0 || i == 99 || i == 199) chk($sformatf("rerun_vec%0d", i), 32'(p0), 32'(run1[i]));
      cycle();
    end
    repeat (60) cycle();

    // Random start/abort/seed traffic with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 59) == 0);
      seed  = 8'($urandom);
      RST   = (i == 200);
      cycle();
    end
    RST = 1'b0; start = 1'b0; abort = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
